// File: rtl/rgmii_pkg.sv
// Shared encodings for the RGMII transmit scheduler: speed codes and the
// TX_CTL per-edge encoding.
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // RGMII carries en on the rising edge and en^er on the falling edge.
    function automatic logic [1:0] ctl_encode(input logic en, input logic er);
        return {en, en ^ er};
    endfunction

    // The unused code 2'b11 runs as gigabit.
    function automatic logic [1:0] speed_decode(input logic [1:0] speed);
        return (speed == 2'b11) ? SPEED_1000 : speed;
    endfunction

endpackage

// File: rtl/rgmii_clk_pattern_gen.sv
// Phase counter, nibble select and forwarded-clock pattern for RGMII TX.
// The *_sel/byte_wrap outputs describe the cycle that starts at the next edge.
module rgmii_clk_pattern_gen
    import rgmii_pkg::*;
#(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed_sel,
    input  logic       hold,
    input  logic       restart,
    output logic       nib_sel,
    output logic [1:0] half_sel,
    output logic       byte_wrap,
    output logic       clk_d1,
    output logic       clk_d2
);

    localparam int DIV_MAX = (DIV_100 > DIV_10) ? DIV_100 : DIV_10;
    localparam int CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

    localparam logic [CNT_W-1:0] LAST_100 = CNT_W'(DIV_100 - 1);
    localparam logic [CNT_W-1:0] LAST_10  = CNT_W'(DIV_10 - 1);
    localparam logic [CNT_W-1:0] HALF_100 = CNT_W'(DIV_100 / 2);
    localparam logic [CNT_W-1:0] HALF_10  = CNT_W'(DIV_10 / 2);
    localparam logic             ODD_100  = 1'((DIV_100 % 2) != 0);
    localparam logic             ODD_10   = 1'((DIV_10 % 2) != 0);

    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_nxt;
    logic [CNT_W-1:0] last_p;
    logic [CNT_W-1:0] half_p;
    logic             odd_div;
    logic             nib_q;
    logic             gig;

    always_comb begin
        gig     = (speed_sel == SPEED_1000);
        last_p  = (speed_sel == SPEED_100) ? LAST_100 : LAST_10;
        half_p  = (speed_sel == SPEED_100) ? HALF_100 : HALF_10;
        odd_div = (speed_sel == SPEED_100) ? ODD_100  : ODD_10;

        // A byte boundary always restarts at phase 0 of nibble 0, so a speed
        // change never lands in the middle of a period.
        phase_nxt = '0;
        nib_sel   = 1'b0;
        if (!(hold || restart || gig)) begin
            if (phase_q == last_p) begin
                nib_sel = ~nib_q;
            end else begin
                phase_nxt = phase_q + CNT_W'(1);
                nib_sel   = nib_q;
            end
        end

        half_sel = 2'b00;
        if (hold) begin
            half_sel = 2'b00;
        end else if (gig) begin
            half_sel = 2'b10;
        end else if (phase_nxt < half_p) begin
            half_sel = 2'b11;
        end else if (odd_div && (phase_nxt == half_p)) begin
            half_sel = 2'b10;
        end

        byte_wrap = !hold && (gig || (nib_sel && (phase_nxt == last_p)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            nib_q   <= 1'b0;
            clk_d1  <= 1'b0;
            clk_d2  <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            nib_q   <= nib_sel;
            clk_d1  <= half_sel[1];
            clk_d2  <= half_sel[0];
        end
    end

endmodule

// File: rtl/rgmii_tx_ddr_sched.sv
// RGMII transmit scheduler: latches GMII bytes at byte boundaries and produces
// per-edge data/ctl/clock values for the DDR output stage at 1000/100/10 Mb/s.
module rgmii_tx_ddr_sched
    import rgmii_pkg::*;
#(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       tx_byte_strobe,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       ctl_d1,
    output logic       ctl_d2,
    output logic       clk_d1,
    output logic       clk_d2,
    output logic [1:0] speed_active
);

    logic       run_q;
    logic [7:0] txd_q;
    logic       en_q;
    logic       er_q;

    logic [1:0] speed_nxt;
    logic [7:0] txd_nxt;
    logic       en_nxt;
    logic       er_nxt;
    logic       gig_nxt;
    logic [1:0] ctl_enc;
    logic [3:0] nib_d1;
    logic [3:0] nib_d2;

    logic       nib_sel;
    logic [1:0] half_sel;
    logic       byte_wrap;

    // Speed and byte are taken together, only in a strobe cycle.
    always_comb begin
        speed_nxt = speed_active;
        txd_nxt   = txd_q;
        en_nxt    = en_q;
        er_nxt    = er_q;
        if (tx_byte_strobe) begin
            speed_nxt = speed_decode(speed);
            txd_nxt   = gmii_txd;
            en_nxt    = gmii_tx_en;
            er_nxt    = gmii_tx_er;
        end

        gig_nxt = (speed_nxt == SPEED_1000);
        ctl_enc = ctl_encode(en_nxt, er_nxt);

        nib_d1 = txd_nxt[3:0];
        nib_d2 = txd_nxt[7:4];
        if (!gig_nxt) begin
            nib_d1 = nib_sel ? txd_nxt[7:4] : txd_nxt[3:0];
            nib_d2 = nib_d1;
        end
    end

    rgmii_clk_pattern_gen #(
        .DIV_100 (DIV_100),
        .DIV_10  (DIV_10)
    ) u_clk_pattern (
        .clk       (clk),
        .rst_n     (rst_n),
        .speed_sel (speed_nxt),
        .hold      (~run_q),
        .restart   (tx_byte_strobe),
        .nib_sel   (nib_sel),
        .half_sel  (half_sel),
        .byte_wrap (byte_wrap),
        .clk_d1    (clk_d1),
        .clk_d2    (clk_d2)
    );

    // Ctl follows the clock level of each half: en while high, en^er while low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q          <= 1'b0;
            tx_byte_strobe <= 1'b0;
            speed_active   <= SPEED_1000;
            txd_q          <= '0;
            en_q           <= 1'b0;
            er_q           <= 1'b0;
            txd_d1         <= '0;
            txd_d2         <= '0;
            ctl_d1         <= 1'b0;
            ctl_d2         <= 1'b0;
        end else begin
            run_q          <= 1'b1;
            tx_byte_strobe <= ~run_q | byte_wrap;
            speed_active   <= speed_nxt;
            txd_q          <= txd_nxt;
            en_q           <= en_nxt;
            er_q           <= er_nxt;
            txd_d1         <= nib_d1;
            txd_d2         <= nib_d2;
            ctl_d1         <= half_sel[1] ? ctl_enc[1] : ctl_enc[0];
            ctl_d2         <= half_sel[0] ? ctl_enc[1] : ctl_enc[0];
        end
    end

endmodule

// File: doc/rgmii_tx_ddr_sched.md
Name: rgmii_tx_ddr_sched

Overview:
- Transmit-side scheduler that drives the generic source-synchronous DDR output stage (one 5-bit data/ctl ODDR instance plus one forwarded-clock ODDR instance with per-edge control).
- Converts a GMII-style byte stream into RGMII rising/falling-edge nibble pairs at 1000/100/10 Mb/s from a single 125 MHz clock.
- Generates the forwarded-clock edge pattern and the byte-accept strobe that paces the upstream MAC.

Parameters:
- DIV_100, 5: clk cycles per RGMII clock period at 100 Mb/s; must be >= 2.
- DIV_10, 50: clk cycles per RGMII clock period at 10 Mb/s; must be >= 2.

Ports:
- clk  in  1  125 MHz transmit clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- speed  in  2  2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 = treated as 1000.
- gmii_txd  in  8  transmit byte.
- gmii_tx_en  in  1  frame enable.
- gmii_tx_er  in  1  transmit error.
- tx_byte_strobe  out  1  registered; inputs are sampled in every cycle where this is high.
- txd_d1  out  4  rising-edge data nibble.
- txd_d2  out  4  falling-edge data nibble.
- ctl_d1  out  1  rising-edge TX_CTL.
- ctl_d2  out  1  falling-edge TX_CTL.
- clk_d1  out  1  forwarded-clock rising-half value.
- clk_d2  out  1  forwarded-clock falling-half value.
- speed_active  out  2  speed currently in effect.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - All outputs are registered.
- Reset values:
  - All data, ctl and clk outputs are 0; the forwarded clock is held low.
  - tx_byte_strobe = 0.
  - speed_active = 2'b10.
  - Phase counter = 0, nibble select = 0.
  - Latched byte, en and er = 0.
- Reset mid-operation: all state clears immediately, with no attempt to finish the current byte.
- First cycle after release: behaves as phase 0, nibble 0, with tx_byte_strobe = 1.
- Gigabit mode (speed_active = 2'b10):
  - tx_byte_strobe is 1 every cycle.
  - A byte sampled in cycle N appears on the outputs in cycle N+1: txd_d1 = txd[3:0], txd_d2 = txd[7:4], ctl_d1 = en, ctl_d2 = en ^ er.
  - clk_d1/clk_d2 = 1/0.
- 10/100 mode:
  - DIV = DIV_100 or DIV_10. Phase counter p runs 0..DIV-1 and wraps.
  - Nibble select toggles at each wrap.
  - Forwarded clock:
    - p < DIV/2 (floor): clk_d1/clk_d2 = 1/1.
    - DIV odd and p == floor(DIV/2): 1/0.
    - Otherwise: 0/0.
    - This gives a 50% duty cycle; DIV = 5 yields a 25 MHz clock.
  - Data:
    - txd_d1 = txd_d2 = the low nibble during nibble 0 and the high nibble during nibble 1, held for the whole period.
  - Ctl:
    - en on both edges while the clock is high.
    - en ^ er on both edges while it is low.
    - On the split cycle: d1 = en, d2 = en ^ er.
  - tx_byte_strobe is high only in the cycle before the output period of nibble 0 begins. This is one pulse per 2*DIV cycles, and the sampled byte appears at the next p = 0.
- Speed changes:
  - speed is sampled only at a byte boundary: the cycle that asserts tx_byte_strobe in the current mode.
  - speed_active and DIV update together with the latch of that byte; a byte is never split across speeds.
  - A change to gigabit while in 10/100 takes effect after the current byte's nibble 1 completes.
- Stable inputs: if gmii_* is held constant across strobes, output is identical per period, with no glitches on the clk pattern at the counter wrap.
- Counter width: ceil(log2(max(DIV_100, DIV_10))) bits; it never exceeds DIV-1.

Decomposition:
- Shared package rgmii_pkg holds the speed encodings (SPEED_10, SPEED_100, SPEED_1000) and the ctl encoding function (en, er) -> {d1, d2}.
- One sub-module, rgmii_clk_pattern_gen:
  - Inputs: speed_active and the DIV values.
  - Outputs: phase counter, wrap pulse, nibble select, clk_d1/clk_d2 and half-select.
  - The top level owns byte latching, strobe generation and speed switching.

Test Plan:
1. Reset, speed = 2'b10, stream bytes 0x55, 0xD5, 0xA3 with en = 1 -> one-cycle latency outputs (5,5), (5,D), (3,A); ctl = 1/1; clk = 1/0 every cycle; strobe constantly 1.
2. speed = 2'b01, byte 0xA3, en = 1, er = 0 -> nibble 3 for 5 cycles then A for 5 cycles; clk pattern 11, 11, 10, 00, 00 repeating; strobe period 10 cycles.
3. speed = 2'b00, en = 1, er = 1 -> clk high for 25 cycles and low for 25; ctl 1 during high, 0 during low; strobe every 100 cycles.
4. Switch speed from 2'b01 to 2'b10 when p = 2 of nibble 0 -> high nibble still output for a full 5 cycles; gigabit starts at the next boundary; speed_active changes with that byte latch.
5. Assert rst_n low at p = 3 in 100 Mb/s mode -> all outputs 0 asynchronously; after release, first strobe in the next cycle.
6. en = 0, er = 1 (carrier extend) at 1000 -> ctl_d1/ctl_d2 = 0/1.
